// File: rtl/uart_rx_monitor.sv
// UART receive monitor: oversampled start/parity/stop checking into a ready/valid character FIFO.
// m_tvalid rises one clock after PUSH; a full FIFO without a same-cycle pop drops the frame and flags overrun.
module uart_rx_monitor #(
   parameter int CLK_DIV    = 4,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          uart_sin,
   input  logic                          msg_on,
   output logic [DATA_BITS-1:0]          m_tdata,
   output logic [2:0]                    m_tuser,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overrun,
   output logic [7:0]                    overrun_count
);
   localparam int   DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int   OS_W    = $clog2(OVERSAMPLE);
   localparam int   BIT_W   = $clog2(DATA_BITS);
   localparam int   PTR_W   = $clog2(FIFO_DEPTH);
   localparam int   ENTRY_W = DATA_BITS + 3;
   localparam logic ODD     = (PARITY == 1);

   typedef enum logic [2:0] {
      S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH
   } state_t;

   state_t               state, state_nxt;
   logic                 sin_meta, sin_sync, sin_prev;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick;
   logic [OS_W-1:0]      tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 par_bit, parity_err, frame_err, brk;
   logic                 samp_mid, samp_full, sample_now, start_det;
   logic                 push_req, wr_en, pop, full, empty, drop;
   logic [ENTRY_W-1:0]   entry;
   logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;

   // Synchroniser idles high so reset never looks like a start edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sin_meta <= 1'b1;
         sin_sync <= 1'b1;
         sin_prev <= 1'b1;
      end else begin
         sin_meta <= uart_sin;
         sin_sync <= sin_meta;
         sin_prev <= sin_sync;
      end
   end

   assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)   div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   assign samp_mid   = tick && (tick_cnt == OS_W'(OVERSAMPLE / 2 - 1));
   assign samp_full  = tick && (tick_cnt == OS_W'(OVERSAMPLE - 1));
   assign start_det  = (state == S_IDLE) && sin_prev && !sin_sync;
   assign sample_now = ((state == S_START) && samp_mid) ||
                       (((state == S_DATA) || (state == S_PARITY) || (state == S_STOP)) && samp_full);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_WAIT_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT_IDLE: if (tick && sin_sync) state_nxt = S_IDLE;
         S_IDLE:      if (start_det) state_nxt = S_START;
         S_START:     if (samp_mid) state_nxt = sin_sync ? S_IDLE : S_DATA;
         S_DATA:      if (samp_full && (bit_cnt == BIT_W'(DATA_BITS - 1)))
                         state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY:    if (samp_full) state_nxt = S_STOP;
         S_STOP:      if (samp_full && (stop_cnt == 1'(STOP_BITS - 1))) state_nxt = S_PUSH;
         S_PUSH:      state_nxt = frame_err ? S_WAIT_IDLE : S_IDLE;
         default:     state_nxt = S_WAIT_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         shift      <= '0;
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else if (start_det) begin
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (sample_now)  tick_cnt <= '0;
         else if (tick)   tick_cnt <= tick_cnt + 1'b1;
         if (sample_now) begin
            case (state)
               S_DATA: begin
                  shift   <= {sin_sync, shift[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               S_PARITY: begin
                  par_bit    <= sin_sync;
                  parity_err <= sin_sync != ((^shift) ^ ODD);
               end
               S_STOP: begin
                  stop_cnt <= stop_cnt + 1'b1;
                  if (!sin_sync) frame_err <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign brk   = (shift == '0) && !par_bit && frame_err;
   assign entry = {brk, frame_err, parity_err, shift};

   // Character FIFO: level tracks occupancy so full and empty never alias.
   assign push_req = (state == S_PUSH) && msg_on;
   assign empty    = (fifo_level == '0);
   assign full     = (fifo_level == (PTR_W + 1)'(FIFO_DEPTH));
   assign pop      = m_tready && !empty;
   assign wr_en    = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;
   assign m_tvalid = !empty;
   assign {m_tuser, m_tdata} = empty ? '0 : fifo_mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (wr_en) fifo_mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_level    <= '0;
         overrun       <= 1'b0;
         overrun_count <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: ;
         endcase
         if (drop) begin
            overrun <= 1'b1;
            if (overrun_count != 8'hFF) overrun_count <= overrun_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: an 8N1 instance and an 8E1 instance driven by serial frames, checked against a frame-level model.
module tb_uart_rx_monitor;
   localparam int BIT = 64;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       sin = 1'b1, sin_p = 1'b1;
   logic       msg_on = 1'b1;
   logic       m_tready = 1'b0;
   int         ready_mode = 0;

   logic [7:0] tdata0, tdata1, ocnt0, ocnt1;
   logic [2:0] tuser0, tuser1;
   logic       tvalid0, tvalid1, ovr0, ovr1;
   logic [4:0] level0, level1;

   logic [10:0] exp_q0[$], exp_q1[$], rx_q0[$], rx_q1[$];
   int n_checks = 0, n_fail = 0;

   uart_rx_monitor u_dut (
      .clock(clock), .resetn(resetn), .uart_sin(sin), .msg_on(msg_on),
      .m_tdata(tdata0), .m_tuser(tuser0), .m_tvalid(tvalid0), .m_tready(m_tready),
      .fifo_level(level0), .overrun(ovr0), .overrun_count(ocnt0));

   uart_rx_monitor #(.PARITY(2)) u_par (
      .clock(clock), .resetn(resetn), .uart_sin(sin_p), .msg_on(msg_on),
      .m_tdata(tdata1), .m_tuser(tuser1), .m_tvalid(tvalid1), .m_tready(m_tready),
      .fifo_level(level1), .overrun(ovr1), .overrun_count(ocnt1));

   always #5 clock = ~clock;

   initial begin
      forever begin
         @(posedge clock); #1;
         case (ready_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clock) begin
      if (resetn && m_tready && tvalid0) rx_q0.push_back({tuser0, tdata0});
      if (resetn && m_tready && tvalid1) rx_q1.push_back({tuser1, tdata1});
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference frame outcome: {break, frame_err, parity_err, data}.
   function automatic logic [10:0] model(input logic [7:0] d, input int par_mode,
                                         input logic pbit, input logic stop);
      logic want, pe, fe, brk;
      want = ($countones(d) % 2) == 1;
      if (par_mode == 1) want = !want;
      pe  = (par_mode != 0) && (pbit != want);
      fe  = !stop;
      brk = (d == 8'h00) && ((par_mode == 0) || !pbit) && fe;
      return {brk, fe, pe, d};
   endfunction

   task automatic hold(input int which, input logic v, input int clks);
      if (which == 0) sin = v; else sin_p = v;
      repeat (clks) @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input int which, input logic [7:0] d, input int par_mode,
                             input logic pbit, input logic stop, input int blen);
      hold(which, 1'b0, blen);
      for (int i = 0; i < 8; i++) hold(which, d[i], blen);
      if (par_mode != 0) hold(which, pbit, blen);
      hold(which, stop, blen);
   endtask

   task automatic drain_and_compare(input string tag);
      int k;
      ready_mode = 1;
      k = 0;
      while ((level0 != 0 || level1 != 0) && k < 3000) begin
         @(negedge clock);
         k++;
      end
      repeat (4) @(negedge clock);
      check_eq({tag, "_drained"}, 32'(level0) + 32'(level1), 0);
      check_eq({tag, "_count0"}, rx_q0.size(), exp_q0.size());
      check_eq({tag, "_count1"}, rx_q1.size(), exp_q1.size());
      for (int i = 0; i < rx_q0.size() && i < exp_q0.size(); i++)
         check_eq({tag, "_beat0"}, 32'(rx_q0[i]), 32'(exp_q0[i]));
      for (int i = 0; i < rx_q1.size() && i < exp_q1.size(); i++)
         check_eq({tag, "_beat1"}, 32'(rx_q1[i]), 32'(exp_q1[i]));
      rx_q0.delete(); rx_q1.delete(); exp_q0.delete(); exp_q1.delete();
   endtask

   initial begin
      logic [7:0] d;
      logic       pb, st;
      int         k;

      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_valid", tvalid0, 0);
      check_eq("rst_data", tdata0, 0);
      check_eq("rst_user", tuser0, 0);
      check_eq("rst_level", level0, 0);
      check_eq("rst_overrun", ovr0, 0);
      check_eq("rst_ocount", ocnt0, 0);
      check_eq("rst_valid_p", tvalid1, 0);
      resetn = 1'b1;
      hold(0, 1'b1, 2 * BIT);

      // Single 0x55 with cycle-level observation of the pop
      ready_mode = 1;
      exp_q0.push_back(model(8'h55, 0, 1'b0, 1'b1));
      fork
         send_frame(0, 8'h55, 0, 1'b0, 1'b1, BIT);
         begin
            k = 0;
            while (!tvalid0 && k < 20 * BIT) begin
               @(negedge clock);
               k++;
            end
            check_eq("t1_valid", tvalid0, 1);
            check_eq("t1_data", tdata0, 8'h55);
            check_eq("t1_user", tuser0, 0);
            check_eq("t1_level", level0, 1);
            @(negedge clock);
            check_eq("t1_level_after_pop", level0, 0);
            check_eq("t1_valid_after_pop", tvalid0, 0);
         end
      join
      hold(0, 1'b1, BIT);
      drain_and_compare("t1");

      // Random clean frames on 8N1 and random parity/stop on 8E1 under random ready
      ready_mode = 2;
      for (int n = 0; n < 8; n++) begin
         d = 8'($urandom);
         exp_q0.push_back(model(d, 0, 1'b0, 1'b1));
         send_frame(0, d, 0, 1'b0, 1'b1, $urandom_range(BIT - 1, BIT + 1));
         hold(0, 1'b1, 32);
      end
      for (int n = 0; n < 8; n++) begin
         d  = 8'($urandom);
         pb = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 3) != 0);
         exp_q1.push_back(model(d, 2, pb, st));
         send_frame(1, d, 2, pb, st, $urandom_range(BIT - 1, BIT + 1));
         hold(1, 1'b1, 32);
      end
      drain_and_compare("rand");

      // Even parity: 0xA3 needs parity bit 0
      exp_q1.push_back(model(8'hA3, 2, 1'b1, 1'b1));
      send_frame(1, 8'hA3, 2, 1'b1, 1'b1, BIT);
      hold(1, 1'b1, 32);
      exp_q1.push_back(model(8'hA3, 2, 1'b0, 1'b1));
      send_frame(1, 8'hA3, 2, 1'b0, 1'b1, BIT);
      hold(1, 1'b1, 32);
      drain_and_compare("parity");

      // Framing error, recovery, then a 20-bit break
      exp_q0.push_back(model(8'h3C, 0, 1'b0, 1'b0));
      send_frame(0, 8'h3C, 0, 1'b0, 1'b0, BIT);
      hold(0, 1'b0, BIT);
      hold(0, 1'b1, BIT);
      exp_q0.push_back(model(8'h5A, 0, 1'b0, 1'b1));
      send_frame(0, 8'h5A, 0, 1'b0, 1'b1, BIT);
      hold(0, 1'b1, BIT);
      drain_and_compare("ferr");
      exp_q0.push_back(model(8'h00, 0, 1'b0, 1'b0));
      hold(0, 1'b0, 20 * BIT);
      check_eq("brk_beats_low", rx_q0.size(), 1);
      hold(0, 1'b1, 2 * BIT);
      drain_and_compare("brk");

      // Overflow: 17 frames with no consumer
      ready_mode = 0;
      for (int n = 0; n < 17; n++) begin
         if (n < 16) exp_q0.push_back(model(8'(n), 0, 1'b0, 1'b1));
         send_frame(0, 8'(n), 0, 1'b0, 1'b1, BIT);
         hold(0, 1'b1, 16);
      end
      check_eq("ovf_level", level0, 16);
      check_eq("ovf_overrun", ovr0, 1);
      check_eq("ovf_count", ocnt0, 1);
      drain_and_compare("ovf");
      check_eq("ovf_sticky", ovr0, 1);

      // Idle glitch and msg_on gating
      hold(0, 1'b0, 20);
      hold(0, 1'b1, 2 * BIT);
      msg_on = 1'b0;
      send_frame(0, 8'h41, 0, 1'b0, 1'b1, BIT);
      hold(0, 1'b1, BIT);
      msg_on = 1'b1;
      exp_q0.push_back(model(8'h42, 0, 1'b0, 1'b1));
      send_frame(0, 8'h42, 0, 1'b0, 1'b1, BIT);
      hold(0, 1'b1, BIT);
      drain_and_compare("glitch_msg");

      // Reset in the middle of DATA while the line is low
      fork
         send_frame(0, 8'h00, 0, 1'b0, 1'b1, BIT);
         begin
            repeat (3 * BIT + 20) @(posedge clock);
            #1 resetn = 1'b0;
            repeat (3) @(posedge clock);
            #1 resetn = 1'b1;
         end
      join
      hold(0, 1'b1, 2 * BIT);
      check_eq("mrst_level", level0, 0);
      check_eq("mrst_valid", tvalid0, 0);
      check_eq("mrst_overrun", ovr0, 0);
      check_eq("mrst_ocount", ocnt0, 0);
      exp_q0.push_back(model(8'h7E, 0, 1'b0, 1'b1));
      send_frame(0, 8'h7E, 0, 1'b0, 1'b1, BIT);
      hold(0, 1'b1, BIT);
      drain_and_compare("mrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Parametrised, synthesisable successor to the bench-only UART receiver used to capture MicroBlaze stdout in simulation.
- Oversamples the serial input from a programmable divider and checks start, parity and stop framing.
- Buffers received characters with their error flags in an internal FIFO and presents them on a ready/valid stream.
- Sits on the FPGA-side txd of the UART; usable in both benches and hardware debug builds.

Parameters:
- CLK_DIV, 4, clock cycles per oversample tick (>=1).
- OVERSAMPLE, 16, ticks per bit (even, >=4).
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits (1 or 2).
- FIFO_DEPTH, 16, character buffer depth (power of 2, >=2).

Ports:
- clock  in  1  sole clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- uart_sin  in  1  serial input, asynchronous to clock.
- msg_on  in  1  when 0, completed frames are discarded and not pushed.
- m_tdata  out  DATA_BITS  received character.
- m_tuser  out  3  {break, frame_err, parity_err} for m_tdata.
- m_tvalid  out  1  FIFO not empty.
- m_tready  in  1  consumer accept.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overrun  out  1  sticky; set when a frame was dropped because the FIFO was full.
- overrun_count  out  8  saturating count (stops at 255) of dropped frames.

Behaviour:
- Reset values: all outputs 0; FSM in WAIT_IDLE; FIFO empty; counters 0.
- Input path: uart_sin passes through a 2-flop synchroniser, reset value 1; all FSM decisions use the synchronised value.
- Tick generator: a pulse every CLK_DIV clocks, free-running.
- Bit-tick counter: reset to 0 on start detection.
- FSM states: WAIT_IDLE, IDLE, START, DATA, PARITY, STOP, PUSH.
  - WAIT_IDLE -> IDLE once the synchronised line is 1 on a tick. This stops reset from releasing mid-frame into a false start.
  - IDLE -> START on a synchronised 1->0 transition.
  - START: sample at tick OVERSAMPLE/2-1. Sample 1 -> IDLE (glitch rejected, nothing pushed). Sample 0 -> DATA.
  - DATA: sample every OVERSAMPLE ticks thereafter, LSB first, DATA_BITS samples.
  - DATA -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: parity_err = received parity bit differs from the odd/even parity computed over the data.
  - STOP: sample STOP_BITS stop bits. frame_err = any stop sample 0.
  - break = all data bits 0, parity bit (if any) 0, and frame_err.
  - STOP -> PUSH after the last stop sample.
  - PUSH (one cycle): write {flags, data} to the FIFO if msg_on=1, then -> IDLE.
  - After a frame_err, go IDLE -> WAIT_IDLE so a held-low break line does not retrigger. This applies when frame_err=1.
- Latency: m_tvalid rises one clock after the PUSH cycle when the FIFO was empty.
- FIFO and stream:
  - Synchronous FIFO; m_tdata/m_tuser are the head entry.
  - Pop when m_tvalid & m_tready.
  - Data and flags are stable while m_tvalid=1 and m_tready=0.
- Full FIFO:
  - If a push arrives while full without a same-cycle pop, the frame is dropped, overrun is set and overrun_count increments (saturating).
  - A same-cycle pop and push on a full FIFO are both accepted; level stays FIFO_DEPTH.
- Empty FIFO: no pop occurs and m_tvalid=0 regardless of m_tready.
- Pointers wrap modulo FIFO_DEPTH; level distinguishes full from empty.
- overrun clears only on reset.
- Reset mid-frame: the partial frame is lost, the FIFO is flushed, and the FSM returns to WAIT_IDLE.
- Bit period = CLK_DIV*OVERSAMPLE clocks. The input baud must be within ±2% of this.

Test Plan:
- Defaults (bit period 64 clocks), m_tready=1, send 0x55 8N1 -> one beat: m_tdata=0x55, m_tuser=000; fifo_level back to 0 the cycle after the pop.
- PARITY=2, send 0xA3 with parity bit 1 (correct is 0) -> m_tdata=0xA3, m_tuser=001. Then 0xA3 with parity 0 -> m_tuser=000.
- Send 0x3C with a 0 stop bit, line returned high 1 bit later -> m_tuser=010, next frame received clean. Then hold line low for 20 bit periods -> exactly one beat, data 0x00, m_tuser=110, no further beats until the line is high.
- m_tready=0, send 17 characters 0x00..0x10 -> fifo_level=16, overrun=1, overrun_count=1. Drain -> 0x00..0x0F in order, 0x10 absent.
- Low glitch of 20 clocks on idle line -> no push, FSM back in IDLE; msg_on=0 during 0x41 -> no beat.
- Assert resetn low in the middle of DATA for 3 clocks, release while line low -> FIFO empty, no false character. The next valid frame 0x7E is received correctly.
